// File: rtl/ysyx_22050612_exu_seq.sv
// ysyx_22050612_exu_seq: multi-cycle EXU sequencer (fetch/decode/exec/mem/wb); YSYX_22050612_EXU_SEQ_TIMEOUT_EN adds a memory-wait watchdog
module ysyx_22050612_exu_seq #(
  parameter int TO_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        ir_we,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        halt,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        gpr_we_en,
  output logic        pc_we,
  output logic [2:0]  state,
  output logic        busy,
  output logic [63:0] inst_cnt,
  output logic        err
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;
  state_t cur, nxt;
  logic to_hit;
`ifdef YSYX_22050612_EXU_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt;
  assign to_hit = (cur == FETCH || cur == MEM) && to_cnt == TW'(TO_CYC - 1);
  // restarts on every state change, so each FETCH/MEM wait gets a fresh budget
  always_ff @(posedge clk or posedge rst)
    if (rst) to_cnt <= '0;
    else to_cnt <= (nxt != cur) ? '0 : (cur == FETCH || cur == MEM) ? to_cnt + 1'b1 : to_cnt;
`else
  assign to_hit = 1'b0;
  if (TO_CYC < 1) begin : g_to_cyc_unused
  end
`endif
  always_comb begin
    nxt = cur;
    imem_req = 1'b0;
    ir_we = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    gpr_we_en = 1'b0;
    pc_we = 1'b0;
    case (cur)
      IDLE: nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ir_we = imem_ack;
        nxt = imem_ack ? DECODE : to_hit ? ERR : FETCH;
      end
      DECODE: nxt = halt ? HALT : (is_load && is_store) ? ERR : EXEC;
      EXEC: nxt = (is_load || is_store) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_store;
        nxt = dmem_ack ? WB : to_hit ? ERR : MEM;
      end
      WB: begin
        pc_we = 1'b1;
        gpr_we_en = ~is_store;
        nxt = FETCH;
      end
      default: nxt = cur;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= IDLE;
      inst_cnt <= '0;
      err <= 1'b0;
    end else begin
      cur <= nxt;
      inst_cnt <= inst_cnt + {63'd0, cur == WB};
      err <= err | (nxt == ERR);
    end
  assign state = cur;
  assign busy = !(cur == IDLE || cur == HALT || cur == ERR);
endmodule

// File: tb/tb_ysyx_22050612_exu_seq.sv
// tb_ysyx_22050612_exu_seq: scoreboard bench for the EXU sequencer
module tb_ysyx_22050612_exu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_ack, ir_we, is_load, is_store, halt;
  logic dmem_req, dmem_we, dmem_ack, gpr_we_en, pc_we, busy, err;
  logic [2:0] state;
  logic [63:0] inst_cnt;
  int checks = 0;
  int failures = 0;
  longint exp_cnt = 0;
  typedef struct {
    logic gpr;
    logic [63:0] cnt;
    int cyc;
    int dreq;
  } exp_t;
  exp_t sb[$];

  ysyx_22050612_exu_seq #(.TO_CYC(4)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
    .is_load(is_load), .is_store(is_store), .halt(halt), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .gpr_we_en(gpr_we_en), .pc_we(pc_we),
    .state(state), .busy(busy), .inst_cnt(inst_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_cnt = 0;
    sb.delete();
  endtask

  // starts and ends at a negedge with the sequencer in FETCH
  task automatic do_instr(input bit ld, input bit st, input int iw, input int dw, input bit noise);
    exp_t e, r;
    bit mem, done;
    int idx, bad, irs, pcs, dreq, es, mend;
    mem = ld || st;
    mend = iw + 3 + dw;
    e.gpr = !st;
    e.cnt = exp_cnt + 1;
    e.cyc = 5 + iw + (mem ? dw + 1 : 0);
    e.dreq = mem ? dw + 1 : 0;
    sb.push_back(e);
    exp_cnt++;
    is_load = ld;
    is_store = st;
    halt = 1'b0;
    done = 0;
    idx = 0;
    bad = 0;
    irs = 0;
    pcs = 0;
    dreq = 0;
    r = e;
    while (!done && idx < 200) begin
      es = idx <= iw ? 1 : idx == iw + 1 ? 2 : idx == iw + 2 ? 3 : (mem && idx <= mend) ? 4 : 5;
      imem_ack = (idx == iw) || (noise && es != 1);
      dmem_ack = (mem && idx == mend) || (noise && es != 4);
      #1;
      if (state !== 3'(es)) bad++;
      if (imem_req !== (es == 1)) bad++;
      if (dmem_we !== (dmem_req && st)) bad++;
      if (gpr_we_en && !pc_we) bad++;
      irs += int'(ir_we);
      dreq += int'(dmem_req);
      if (pc_we) begin
        pcs++;
        r = sb.pop_front();
        chk("wb_gpr_we_en", gpr_we_en, r.gpr);
        done = 1;
      end
      idx++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (!done) chk("retire_timeout", 0, 1);
    chk("seq_bad_cycles", bad, 0);
    chk("ir_we_pulses", irs, 1);
    chk("pc_we_pulses", pcs, 1);
    chk("dmem_req_cycles", dreq, r.dreq);
    chk("instr_latency", idx + 1, r.cyc);
    chk("inst_cnt", inst_cnt, r.cnt);
    chk("back_to_fetch", state, 1);
  endtask

  initial begin
    int bad;
    logic [63:0] frozen;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    is_load = 1'b0;
    is_store = 1'b0;
    halt = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_inst_cnt", inst_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_hold", state, 0);
    @(negedge clk);
    chk("first_fetch", state, 1);
    chk("fetch_busy", busy, 1);
    do_instr(0, 0, 0, 0, 0);
    do_instr(1, 0, 0, 3, 0);
    do_instr(0, 1, 2, 1, 1);
    do_instr(1, 0, 1, 0, 1);
    do_instr(0, 0, 3, 0, 1);
    do_instr(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      bit l;
      l = 1'($urandom_range(0, 1));
      do_instr(l, !l && $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    // halt: terminal, no more fetches, counter frozen
    frozen = inst_cnt;
    halt = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("halt_decode", state, 2);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      #1;
      if (state !== 3'd6 || imem_req || busy || pc_we || ir_we) bad++;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    chk("halt_state", state, 6);
    chk("halt_terminal", bad, 0);
    chk("halt_cnt_frozen", inst_cnt, frozen);
    chk("halt_err", err, 0);
    // load+store conflict -> ERR
    do_reset();
    is_load = 1'b1;
    is_store = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("conflict_state", state, 7);
    chk("conflict_err", err, 1);
    chk("conflict_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("err_terminal", state, 7);
    chk("err_sticky", err, 1);
    // async reset mid-MEM
    do_reset();
    do_instr(0, 0, 0, 0, 0);
    is_load = 1'b1;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("mem_req_before_rst", dmem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_dmem_req", dmem_req, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_inst_cnt", inst_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    is_load = 1'b0;
    @(negedge clk);
    chk("refetch_state", state, 1);
    chk("refetch_req", imem_req, 1);
    chk("refetch_cnt", inst_cnt, 0);
`ifdef YSYX_22050612_EXU_SEQ_TIMEOUT_EN
    do_reset();
    repeat (4) @(negedge clk);
    chk("to_fetch_state", state, 7);
    chk("to_fetch_err", err, 1);
    do_reset();
    repeat (3) @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("to_last_ack_state", state, 2);
    chk("to_last_ack_err", err, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
